// File: rtl/jk_rr_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : jk_rr_arbiter_pkg                                           |
// | Description : JK command encodings, default sizes, lock FSM state type    |
// |               and the per-bit JK next-state helper.                       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package jk_rr_arbiter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_WIDTH   = 8;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    function automatic logic jk_next(input logic cur, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = cur;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            default: nxt = ~cur;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_rr_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | Module      : jk_rr_arbiter_if                                            |
// | Description : Requester-side bundle of the JK round-robin arbiter.        |
// |               Optional macro JK_ARB_LOCK_EN adds the lock vector.         |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

interface jk_rr_arbiter_if
    import jk_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] j_bus;
    logic [NUM_REQ*WIDTH-1:0] k_bus;
`ifdef JK_ARB_LOCK_EN
    logic [NUM_REQ-1:0]       lock;
`endif
    logic [NUM_REQ-1:0]       gnt;
    logic [IDW-1:0]           gnt_id;
    logic                     gnt_valid;
    logic [WIDTH-1:0]         q;

`ifdef JK_ARB_LOCK_EN
    modport master (output req, j_bus, k_bus, lock, input gnt, gnt_id, gnt_valid, q);
    modport slave  (input req, j_bus, k_bus, lock, output gnt, gnt_id, gnt_valid, q);
`else
    modport master (output req, j_bus, k_bus, input gnt, gnt_id, gnt_valid, q);
    modport slave  (input req, j_bus, k_bus, output gnt, gnt_id, gnt_valid, q);
`endif

endinterface

`default_nettype wire

// File: rtl/jk_cell.sv
// +--------------------------------------------------------------------------+
// | Module      : jk_cell                                                     |
// | Description : One JK storage bit with synchronous reset and enable.       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_cell
    import jk_rr_arbiter_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    input  wire logic j,
    input  wire logic k,
    output logic      q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = jk_next(q_q, j, k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : jk_rr_arbiter                                               |
// | Description : Round-robin arbiter applying one requester's J/K vectors    |
// |               per cycle to a shared JK register. Optional macro           |
// |               JK_ARB_LOCK_EN adds owner locking.                          |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_rr_arbiter
    import jk_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  wire logic      clk,
    input  wire logic      rst,
    jk_rr_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;
    logic               gnt_valid_q, gnt_valid_d;

    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_win_inc;
    logic [WIDTH-1:0]   w_j_sel;
    logic [WIDTH-1:0]   w_k_sel;
    logic [WIDTH-1:0]   w_q;

    // Index arithmetic modulo NUM_REQ, which need not be a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDW'(s);
    endfunction

`ifdef JK_ARB_LOCK_EN
    lock_state_e    state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;

    always_comb begin
        w_eligible = bus.req;
        if (state_q == ST_LOCKED) begin
            w_eligible          = '0;
            w_eligible[owner_q] = bus.req[owner_q];
        end
    end
`else
    assign w_eligible = bus.req;
`endif

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            if (!w_found && w_eligible[wrap_add(ptr_q, o)]) begin
                w_found = 1'b1;
                w_win   = wrap_add(ptr_q, o);
            end
        end
    end

    assign w_win_inc = wrap_add(w_win, 1);

    always_comb begin
        w_j_sel = '0;
        w_k_sel = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_win == IDW'(n)) begin
                w_j_sel = bus.j_bus[n*WIDTH +: WIDTH];
                w_k_sel = bus.k_bus[n*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            jk_cell u_cell (
                .clk (clk),
                .rst (rst),
                .en  (w_found),
                .j   (w_j_sel[i]),
                .k   (w_k_sel[i]),
                .q   (w_q[i])
            );
        end
    endgenerate

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = '0;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = 1'b0;
        if (w_found) begin
            gnt_d[w_win] = 1'b1;
            gnt_id_d     = w_win;
            gnt_valid_d  = 1'b1;
            ptr_d        = w_win_inc;
        end
`ifdef JK_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == ST_UNLOCKED) begin
            if (w_found && bus.lock[w_win]) begin
                state_d = ST_LOCKED;
                owner_d = w_win;
                ptr_d   = ptr_q;
            end
        end else begin
            // Pointer stays frozen while locked and resumes just past the owner.
            ptr_d = ptr_q;
            if (!bus.lock[owner_q]) begin
                state_d = ST_UNLOCKED;
                ptr_d   = wrap_add(owner_q, 1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
`ifdef JK_ARB_LOCK_EN
            state_q     <= ST_UNLOCKED;
            owner_q     <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef JK_ARB_LOCK_EN
            state_q     <= state_d;
            owner_q     <= owner_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.q         = w_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_jk_rr_arbiter                                            |
// | Description : Self-checking bench for jk_rr_arbiter (default build).      |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jk_rr_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jk_rr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    jk_rr_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    logic [W-1:0]  m_q     = '0;
    logic [NR-1:0] m_gnt   = '0;
    int            m_id    = 0;
    int            m_ptr   = 0;
    bit            m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: scan from the pointer with modular arithmetic, apply JK truth table.
    always @(posedge clk) begin
        int win;
        if (rst) begin
            m_q = '0; m_gnt = '0; m_id = 0; m_valid = 1'b0; m_ptr = 0;
        end else begin
            win = -1;
            for (int o = 0; o < NR; o++) begin
                if (win < 0 && bus.req[(m_ptr + o) % NR]) win = (m_ptr + o) % NR;
            end
            if (win >= 0) begin
                for (int i = 0; i < W; i++) begin
                    case ({bus.j_bus[win*W + i], bus.k_bus[win*W + i]})
                        2'b00: m_q[i] = m_q[i];
                        2'b01: m_q[i] = 1'b0;
                        2'b10: m_q[i] = 1'b1;
                        default: m_q[i] = ~m_q[i];
                    endcase
                end
                m_gnt   = NR'(1) << win;
                m_id    = win;
                m_valid = 1'b1;
                m_ptr   = (win + 1) % NR;
            end else begin
                m_gnt   = '0;
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_gnt", 32'(bus.gnt), 32'(m_gnt));
            check("model_valid", 32'(bus.gnt_valid), 32'(m_valid));
            check("model_q", 32'(bus.q), 32'(m_q));
            if (m_valid) check("model_id", 32'(bus.gnt_id), 32'(m_id));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_jk(input int n, input logic [W-1:0] j, input logic [W-1:0] k);
        bus.j_bus[n*W +: W] = j;
        bus.k_bus[n*W +: W] = k;
    endtask

    int            exp_ids[5] = '{0, 1, 2, 3, 0};
    logic [W-1:0]  exp_q3[5]  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
    int            exp_rot[3] = '{3, 0, 1};

    initial begin
        bus.req   = '0;
        bus.j_bus = '0;
        bus.k_bus = '0;

        // Reset held two cycles with everyone requesting
        bus.req = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        step();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_valid", 32'(bus.gnt_valid), 32'h0);
        check("rst_q", 32'(bus.q), 32'h00);
        rst = 1'b0;
        step();
        check("first_gnt", 32'(bus.gnt), 32'b0001);
        check("first_id", 32'(bus.gnt_id), 32'd0);

        // Single requester: set/clear then toggle
        bus.req = 4'b0001;
        set_jk(0, 8'hF0, 8'h0F);
        step();
        check("single_q_setclr", 32'(bus.q), 32'hF0);
        check("single_id", 32'(bus.gnt_id), 32'd0);
        set_jk(0, 8'hFF, 8'hFF);
        step();
        check("single_q_tgl", 32'(bus.q), 32'h0F);

        // All requesting with toggle on bit 0, starting from a fresh pointer
        bus.req = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int n = 0; n < NR; n++) set_jk(n, 8'h01, 8'h01);
        for (int s = 0; s < 5; s++) begin
            step();
            check("rr_id", 32'(bus.gnt_id), 32'(exp_ids[s]));
            check("rr_q", 32'(bus.q), 32'(exp_q3[s]));
        end

        // Rotation past requester 2 with a gap at index 2
        bus.j_bus = '0;
        bus.k_bus = '0;
        bus.req = 4'b0100;
        step();
        check("rot_pre_id", 32'(bus.gnt_id), 32'd2);
        bus.req = 4'b1011;
        for (int s = 0; s < 3; s++) begin
            step();
            check("rot_id", 32'(bus.gnt_id), 32'(exp_rot[s]));
        end

        // Idle cycle leaves the pointer where it was
        bus.req = '0;
        step();
        check("idle_valid", 32'(bus.gnt_valid), 32'h0);
        check("idle_gnt", 32'(bus.gnt), 32'h0);
        bus.req = 4'b1111;
        step();
        check("after_idle_id", 32'(bus.gnt_id), 32'd2);

        // Reset coinciding with a request
        rst = 1'b1;
        bus.req = 4'b0100;
        set_jk(2, 8'hFF, 8'h00);
        step();
        check("rst_req_q", 32'(bus.q), 32'h00);
        check("rst_req_gnt", 32'(bus.gnt), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_gnt", 32'(bus.gnt), 32'b0100);
        check("post_rst_q", 32'(bus.q), 32'hFF);
        step();
        check("sole_again_gnt", 32'(bus.gnt), 32'b0100);
        check("sole_again_valid", 32'(bus.gnt_valid), 32'h1);

        bus.req = '0;
        step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
